// File: rtl/biriscv_div_responder.sv
// ---------------------------------------------------------------------------
// biriscv_div_responder: iterative RV32M DIV/DIVU/REM/REMU responder unit.
// Optional early-out build: BIRISCV_DIV_EARLY_OUT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module biriscv_div_responder #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [31:0] opcode_ra_operand_i,
  input  logic [31:0] opcode_rb_operand_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        div_complete_o,
  output logic [31:0] div_result_o
);

  localparam int         C_ITERS    = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] C_CNT_LOAD = 5'(C_ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  count_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        want_rem_q;
  logic        busy_q;
  logic        complete_q;
  logic [31:0] result_q;

  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [32:0] w_shift;

  // Decode and operand conditioning for the start cycle
  logic        w_is_div;
  logic        w_signed;
  logic        w_want_rem;
  logic        w_start;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_b_zero;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic        w_unused_opcode;

  assign w_is_div   = (opcode_opcode_i[6:0] == 7'b0110011) &&
                      (opcode_opcode_i[31:25] == 7'b0000001) &&
                      opcode_opcode_i[14];
  assign w_signed   = ~opcode_opcode_i[12];
  assign w_want_rem = opcode_opcode_i[13];
  assign w_start    = opcode_valid_i & w_is_div & ~flush_i & (state_q == ST_IDLE);
  assign w_a_neg    = w_signed & opcode_ra_operand_i[31];
  assign w_b_neg    = w_signed & opcode_rb_operand_i[31];
  assign w_b_zero   = (opcode_rb_operand_i == 32'd0);
  assign w_a_abs    = w_a_neg ? (32'd0 - opcode_ra_operand_i) : opcode_ra_operand_i;
  assign w_b_abs    = w_b_neg ? (32'd0 - opcode_rb_operand_i) : opcode_rb_operand_i;
  assign w_unused_opcode = &{1'b0, opcode_opcode_i[24:15], opcode_opcode_i[11:7]};

  // Restoring step(s): 33-bit partial remainder compared against the divisor
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    w_shift = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_shift = {rem_d, quo_d[31]};
      quo_d   = {quo_d[30:0], 1'b0};
      if (w_shift >= {1'b0, dvs_q}) begin
        w_shift  = w_shift - {1'b0, dvs_q};
        quo_d[0] = 1'b1;
      end
      rem_d = w_shift[31:0];
    end
  end

  logic [31:0] w_quo_fin;
  logic [31:0] w_rem_fin;
  logic [31:0] w_final;

  assign w_quo_fin = q_neg_q ? (32'd0 - quo_d) : quo_d;
  assign w_rem_fin = r_neg_q ? (32'd0 - rem_d) : rem_d;
  assign w_final   = want_rem_q ? w_rem_fin : w_quo_fin;

  logic        w_early;
  logic [31:0] w_early_res;

`ifdef BIRISCV_DIV_EARLY_OUT_EN
  logic w_ovf;
  logic w_small;

  assign w_ovf       = w_signed && (opcode_ra_operand_i == 32'h8000_0000) &&
                       (opcode_rb_operand_i == 32'hFFFF_FFFF);
  assign w_small     = (w_a_abs < w_b_abs);
  assign w_early     = w_b_zero | w_ovf | w_small;
  assign w_early_res = w_want_rem ? (w_ovf ? 32'd0 : opcode_ra_operand_i)
                                  : (w_b_zero ? 32'hFFFF_FFFF :
                                     w_ovf    ? 32'h8000_0000 : 32'd0);
`else
  assign w_early     = 1'b0;
  assign w_early_res = 32'd0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      want_rem_q <= 1'b0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      result_q   <= '0;
    end else if (flush_i) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          complete_q <= 1'b0;
          if (w_start) begin
            rem_q      <= '0;
            quo_q      <= w_a_abs;
            dvs_q      <= w_b_abs;
            q_neg_q    <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
            r_neg_q    <= w_a_neg;
            want_rem_q <= w_want_rem;
            busy_q     <= 1'b1;
            if (w_early) begin
              state_q    <= ST_DONE;
              count_q    <= '0;
              complete_q <= 1'b1;
              result_q   <= w_early_res;
            end else begin
              state_q <= ST_RUN;
              count_q <= C_CNT_LOAD;
            end
          end
        end
        ST_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (count_q == 5'd0) begin
            state_q    <= ST_DONE;
            complete_q <= 1'b1;
            result_q   <= w_final;
          end else begin
            count_q <= count_q - 5'd1;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          complete_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign div_complete_o = complete_q;
  assign div_result_o   = result_q;

endmodule

`default_nettype wire

// File: tb/tb_biriscv_div_responder.sv
// ---------------------------------------------------------------------------
// tb_biriscv_div_responder: directed scoreboard bench for biriscv_div_responder.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_biriscv_div_responder;

`ifdef BIRISCV_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid1 = 1'b0;
  logic        valid2 = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] opc = '0;
  logic [31:0] ra = '0;
  logic [31:0] rb = '0;
  logic        busy1, cmp1, busy2, cmp2;
  logic [31:0] res1, res2;

  biriscv_div_responder #(.BITS_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .opcode_valid_i(valid1), .opcode_opcode_i(opc),
    .opcode_ra_operand_i(ra), .opcode_rb_operand_i(rb), .flush_i(flush),
    .busy_o(busy1), .div_complete_o(cmp1), .div_result_o(res1));

  biriscv_div_responder #(.BITS_PER_CYCLE(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .opcode_valid_i(valid2), .opcode_opcode_i(opc),
    .opcode_ra_operand_i(ra), .opcode_rb_operand_i(rb), .flush_i(flush),
    .busy_o(busy2), .div_complete_o(cmp2), .div_result_o(res2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  int          start_cyc = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_exp = '0;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  function automatic logic [31:0] mk(input logic [2:0] f3);
    return {7'b0000001, 10'd0, f3, 5'd0, 7'b0110011};
  endfunction

  function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : a;
      return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return f3[1] ? (a % b) : (a / b);
  endfunction

  function automatic int exp_lat(input int bpc, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] aa, bb;
    bit sg, el;
    sg = ~f3[0];
    aa = (sg && a[31]) ? -a : a;
    bb = (sg && b[31]) ? -b : b;
    el = (b == 32'd0) || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (aa < bb);
    if (EARLY && el) return 2;
    return (bpc == 1) ? 34 : 18;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one start cycle; caller is positioned just after a rising edge.
  task automatic issue(input int sel, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input bit push);
    opc = mk(f3);
    ra = a;
    rb = b;
    start_cyc = cyc;
    if (sel == 1) valid1 = 1'b1;
    else valid2 = 1'b1;
    if (push) sb_q.push_back(model_res(f3, a, b));
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  task automatic wait_done(input int sel, input string tag, input int lat_exp);
    bit          seen;
    logic [31:0] exp;
    logic [31:0] obs;
    seen = 1'b0;
    obs = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if ((sel == 1) ? cmp1 : cmp2) begin
        seen = 1'b1;
        obs = (sel == 1) ? res1 : res2;
        break;
      end
    end
    chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    if (seen) begin
      chk({tag, "_lat"}, 32'(cyc - start_cyc + 1), 32'(lat_exp));
      chk({tag, "_res"}, obs, exp);
    end
    last_exp = exp;
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  t_f3 [13] = '{F_DIVU, F_REMU, F_DIV, F_REM, F_DIV, F_DIV, F_REM,
                             F_DIVU, F_REMU, F_DIV, F_REM, F_DIVU, F_REMU};
  logic [31:0] t_a  [13] = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100,
                             32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd3, 32'd3};
  logic [31:0] t_b  [13] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'hFFFF_FFF9,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                             32'd0, 32'd0, 32'd10, 32'd10};

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    int extra;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_cmp1",  {31'd0, cmp1},  32'd0);
    chk("rst_res1",  res1, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    chk("rst_cmp2",  {31'd0, cmp2},  32'd0);
    chk("rst_res2",  res2, 32'd0);
    @(posedge clk);
    #1;

    // MUL encoding must not start the unit
    issue(1, 3'b000, 32'd6, 32'd7, 1'b0);
    @(negedge clk);
    chk("mul_no_start", {31'd0, busy1}, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      issue(1, t_f3[i], t_a[i], t_b[i], 1'b1);
      wait_done(1, $sformatf("op%0d", i), exp_lat(1, t_f3[i], t_a[i], t_b[i]));
    end

    // Flush in cycle 10 of a DIVU, then restart the following cycle
    issue(1, F_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (7) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy1}, 32'd0);
    chk("flush_cmp",  {31'd0, cmp1},  32'd0);
    chk("flush_res",  res1, last_exp);
    issue(1, F_DIVU, 32'd9, 32'd3, 1'b1);
    wait_done(1, "after_flush", 34);

    // Second start while busy is dropped
    issue(1, F_DIVU, 32'd100, 32'd7, 1'b1);
    saved = start_cyc;
    repeat (4) @(posedge clk);
    #1;
    issue(1, F_DIVU, 32'd8, 32'd2, 1'b0);
    start_cyc = saved;
    wait_done(1, "busy_start", 34);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmp1) extra++;
    end
    chk("busy_extra_pulses", 32'(extra), 32'd0);
    @(posedge clk);
    #1;

    // Two bits per cycle
    issue(2, F_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b1);
    wait_done(2, "b2_divu", exp_lat(2, F_DIVU, 32'hFFFF_FFFF, 32'h10));
    issue(2, F_REMU, 32'hFFFF_FFFF, 32'h10, 1'b1);
    wait_done(2, "b2_remu", exp_lat(2, F_REMU, 32'hFFFF_FFFF, 32'h10));
    issue(2, F_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_done(2, "b2_div", exp_lat(2, F_DIV, 32'hFFFF_FF9C, 32'd7));

    // Asynchronous reset mid-run
    issue(1, F_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy1", {31'd0, busy1}, 32'd0);
    chk("arst_cmp1",  {31'd0, cmp1},  32'd0);
    chk("arst_res1",  res1, 32'd0);
    chk("arst_res2",  res2, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1, F_DIVU, 32'd9, 32'd3, 1'b1);
    wait_done(1, "post_rst", 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
